// File: rtl/block_ram_responder.sv
// Block-organised RAM responder for the data cache refill/writeback port.
// One block read or write is accepted per request. ram_ready pulses for one
// cycle after a fixed latency, and read data is returned on block_to_cache.
module block_ram_responder #(
  parameter int OFFSET_WIDTH    = 3,
  parameter int ADDR_WIDTH      = 30,
  parameter int DATA_WIDTH      = 32,
  parameter int BLOCK_IDX_WIDTH = 10,
  parameter int LATENCY         = 4,
  parameter int BLOCK_WIDTH     = DATA_WIDTH << OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en_in,
  input  logic                   ram_write_in,
  input  logic [ADDR_WIDTH-1:0]  ram_addr_in,
  input  logic [BLOCK_WIDTH-1:0] block_wb_in,
  output logic                   ram_ready,
  output logic [BLOCK_WIDTH-1:0] block_to_cache,
  output logic                   busy
);

  localparam int NUM_BLOCKS = 1 << BLOCK_IDX_WIDTH;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [CNT_W-1:0]           count;
  logic                       req_write;
  logic [BLOCK_IDX_WIDTH-1:0] req_idx;
  logic [BLOCK_WIDTH-1:0]     req_block;
  logic                       accept;
  logic                       access;
  logic                       unused_addr;

  logic [BLOCK_WIDTH-1:0] mem [NUM_BLOCKS];

  // Offset bits and address bits above the block index play no part in selection.
  assign unused_addr = ^{ram_addr_in[OFFSET_WIDTH-1:0],
                         ram_addr_in[ADDR_WIDTH-1:OFFSET_WIDTH+BLOCK_IDX_WIDTH]};

  assign accept    = (state == IDLE) && ram_en_in;
  assign access    = (state == BUSY) && (count == '0);
  assign ram_ready = (state == DONE);
  assign busy      = (state != IDLE);

  // Next-state logic; DONE always returns to IDLE so a held request is not re-taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ram_en_in) state_next = BUSY;
      BUSY:    if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Latch request fields on acceptance and count down the access latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_block <= '0;
    end else if (accept) begin
      count     <= CNT_W'(LATENCY - 1);
      req_write <= ram_write_in;
      req_idx   <= ram_addr_in[OFFSET_WIDTH +: BLOCK_IDX_WIDTH];
      req_block <= block_wb_in;
    end else if ((state == BUSY) && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Read data register; only a completing read updates it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) block_to_cache <= '0;
    else if (access && !req_write) block_to_cache <= mem[req_idx];
  end

  // Backing store is not reset; an aborted write never reaches BUSY completion.
  always_ff @(posedge clk) begin
    if (access && req_write) mem[req_idx] <= req_block;
  end

endmodule

// File: tb/tb_block_ram_responder.sv
// Self-checking bench for block_ram_responder with a block-level memory model.
module tb_block_ram_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         ram_en;
  logic         ram_en1;
  logic         ram_write;
  logic [29:0]  ram_addr;
  logic [255:0] block_wb;
  logic         ram_ready, ram_ready1;
  logic [255:0] btc, btc1;
  logic         busy, busy1;

  int checks;
  int errors;

  logic [255:0] model_mem [int];
  logic [255:0] model1 [int];
  logic [255:0] exp_btc;
  logic [255:0] exp_btc1;

  block_ram_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ram_en_in(ram_en), .ram_write_in(ram_write),
    .ram_addr_in(ram_addr), .block_wb_in(block_wb), .ram_ready(ram_ready),
    .block_to_cache(btc), .busy(busy)
  );

  block_ram_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ram_en_in(ram_en1), .ram_write_in(ram_write),
    .ram_addr_in(ram_addr), .block_wb_in(block_wb), .ram_ready(ram_ready1),
    .block_to_cache(btc1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int blk_idx(input logic [29:0] a);
    return int'(a[12:3]);
  endfunction

  // One request on the LATENCY=4 responder; tasks start and end 1 time unit after a rising edge.
  task automatic txn(input bit wr, input logic [29:0] addr, input logic [255:0] blk,
                     input bit hold, input bit scramble);
    int ready_edge;
    int ready_cnt;
    logic [255:0] exp;
    ram_en = 1'b1; ram_write = wr; ram_addr = addr; block_wb = blk;
    @(posedge clk); #1;
    if (wr) model_mem[blk_idx(addr)] = blk;
    else    exp_btc = model_mem[blk_idx(addr)];
    exp = exp_btc;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b expected 1", busy); end
    if (scramble) begin
      ram_en = 1'b0; ram_addr = 30'($urandom); block_wb = rand_block();
    end
    ready_edge = -1; ready_cnt = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      if (ram_ready === 1'b1) begin
        ready_cnt++; ready_edge = k;
        checks++;
        if (btc !== exp) begin errors++; $display("FAIL data: got %h expected %h", btc, exp); end
      end
      if (k == LAT && !hold) ram_en = 1'b0;
    end
    ram_en = 1'b0;
    checks++;
    if (ready_cnt != 1) begin errors++; $display("FAIL ready_count: got %0d expected 1", ready_cnt); end
    checks++;
    if (ready_edge != LAT) begin errors++; $display("FAIL ready_edge: got %0d expected %0d", ready_edge, LAT); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_done: busy got %b expected 0", busy); end
  endtask

  // One request on the LATENCY=1 responder, with the request held through DONE.
  task automatic lat1_txn(input bit wr, input logic [29:0] addr, input logic [255:0] blk);
    int ready_edge;
    int ready_cnt;
    ram_en1 = 1'b1; ram_write = wr; ram_addr = addr; block_wb = blk;
    @(posedge clk); #1;
    if (wr) model1[blk_idx(addr)] = blk;
    else    exp_btc1 = model1[blk_idx(addr)];
    ready_edge = -1; ready_cnt = 0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      if (ram_ready1 === 1'b1) begin
        ready_cnt++; ready_edge = k;
        checks++;
        if (btc1 !== exp_btc1) begin errors++; $display("FAIL lat1_data: got %h expected %h", btc1, exp_btc1); end
      end
    end
    ram_en1 = 1'b0;
    checks++;
    if (ready_cnt != 1) begin errors++; $display("FAIL lat1_ready_count: got %0d expected 1", ready_cnt); end
    checks++;
    if (ready_edge != 1) begin errors++; $display("FAIL lat1_ready_edge: got %0d expected 1", ready_edge); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL lat1_reaccept: busy got %b expected 0", busy1); end
  endtask

  task automatic test_reset();
    rst = 1'b0; ram_en = 1'b0; ram_en1 = 1'b0; ram_write = 1'b0; ram_addr = '0; block_wb = '0;
    exp_btc = '0; exp_btc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ram_ready !== 1'b0 || busy !== 1'b0 || btc !== '0) begin
      errors++; $display("FAIL reset_state: ready=%b busy=%b data=%h expected 0/0/0", ram_ready, busy, btc);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = 32'(i + 1) * 32'h11;
    txn(1'b1, 30'h40, b, 1'b0, 1'b0);
    txn(1'b0, 30'h47, '0, 1'b0, 1'b0);
  endtask

  task automatic test_latency1();
    logic [255:0] b;
    b = rand_block();
    lat1_txn(1'b1, 30'h100, b);
    lat1_txn(1'b0, 30'h105, '0);
  endtask

  task automatic test_aliasing_stability();
    txn(1'b1, 30'h40, rand_block(), 1'b1, 1'b0);
    txn(1'b0, 30'h40 + (30'd1 << 13), '0, 1'b0, 1'b1);
    txn(1'b1, 30'h2A8, rand_block(), 1'b0, 1'b1);
    txn(1'b0, 30'h2AF, '0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    txn(1'b1, 30'h80, rand_block(), 1'b0, 1'b0);
    txn(1'b0, 30'h40, '0, 1'b0, 1'b0);
    ram_en = 1'b1; ram_write = 1'b1; ram_addr = 30'h80; block_wb = rand_block();
    @(posedge clk); #1;
    ram_en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    exp_btc = '0; exp_btc1 = '0;
    checks++;
    if (ram_ready !== 1'b0 || busy !== 1'b0 || btc !== '0) begin
      errors++; $display("FAIL async_reset: ready=%b busy=%b data=%h expected 0/0/0", ram_ready, busy, btc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 30'h80, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [29:0] a_addr, b_addr;
    logic [255:0] a_blk, exp_b;
    int edges [2];
    int n;
    for (int it = 0; it < 2; it++) begin
      a_addr = 30'h3C0 + 30'(it);
      b_addr = (it == 0) ? 30'h41 : 30'h3C5;
      a_blk = rand_block();
      ram_en = 1'b1; ram_write = 1'b1; ram_addr = a_addr; block_wb = a_blk;
      @(posedge clk); #1;
      model_mem[blk_idx(a_addr)] = a_blk;
      exp_b = model_mem[blk_idx(b_addr)];
      n = 0; edges[0] = -1; edges[1] = -1;
      for (int k = 1; k <= 2 * LAT + 3; k++) begin
        @(posedge clk); #1;
        if (ram_ready === 1'b1) begin
          if (n < 2) edges[n] = k;
          n++;
          checks++;
          if (btc !== ((n == 1) ? exp_btc : exp_b)) begin
            errors++; $display("FAIL b2b_data%0d: got %h expected %h", n, btc, (n == 1) ? exp_btc : exp_b);
          end
        end
        if (k == LAT + 1) begin ram_write = 1'b0; ram_addr = b_addr; block_wb = rand_block(); end
        if (k == 2 * LAT + 2) ram_en = 1'b0;
      end
      exp_btc = exp_b;
      checks++;
      if (n != 2 || edges[0] != LAT || edges[1] != 2 * LAT + 2) begin
        errors++; $display("FAIL b2b_pulses: got n=%0d at %0d,%0d expected 2 at %0d,%0d",
                           n, edges[0], edges[1], LAT, 2 * LAT + 2);
      end
    end
  endtask

  task automatic test_random();
    int idxs [4];
    logic [29:0] a;
    int j;
    bit wr;
    idxs[0] = 5; idxs[1] = 6; idxs[2] = 7; idxs[3] = 300;
    for (int i = 0; i < 4; i++) begin
      a = (30'($urandom) & 30'h3FFF_E000) | (30'(idxs[i]) << 3) | (30'($urandom) & 30'h7);
      txn(1'b1, a, rand_block(), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      j = int'($urandom_range(3, 0));
      wr = 1'($urandom);
      a = (30'($urandom) & 30'h3FFF_E000) | (30'(idxs[j]) << 3) | (30'($urandom) & 30'h7);
      txn(wr, a, rand_block(), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_latency1();
    test_aliasing_stability();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
